// File: rtl/minterm_sweep_pkg.sv
//------------------------------------------------------------------------------
// Module  : minterm_sweep_pkg
// Brief   : Shared state encodings and sizes for the minterm sweep checker.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package minterm_sweep_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int N_MINTERMS = 16;
    localparam int M_W        = 4;
    localparam int LAT_W      = 3;
endpackage

`default_nettype wire

// File: rtl/sweep_slot_counter.sv
//------------------------------------------------------------------------------
// Module  : sweep_slot_counter
// Brief   : Minterm index and per-slot latency counter; flags the capture cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sweep_slot_counter
    import minterm_sweep_pkg::*;
#(
    parameter int DUT_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           run,
    output logic [M_W-1:0] m,
    output logic           capture,
    output logic           last
);

    localparam logic [LAT_W-1:0] LAT_V = LAT_W'(DUT_LAT);

    logic [LAT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [M_W-1:0]   m_q, m_d;

    assign capture = run && (wait_cnt_q == LAT_V);
    assign last    = (m_q == M_W'(N_MINTERMS - 1));
    assign m       = m_q;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        m_d        = m_q;
        if (clear) begin
            wait_cnt_d = '0;
            m_d        = '0;
        end else if (capture) begin
            wait_cnt_d = '0;
            // The last minterm is terminal: m parks at 15 instead of wrapping.
            if (!last) begin
                m_d = m_q + 1'b1;
            end
        end else if (run) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            m_q        <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            m_q        <= m_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/minterm_sweep_checker.sv
//------------------------------------------------------------------------------
// Module  : minterm_sweep_checker
// Brief   : Sweeps minterms 0..15 through a registered stage, captures a truth
//           table and compares it to EXPECTED. Optional MINTERM_SWEEP_FAIL_LOG_EN
//           adds first_fail / fail_cnt. The table port is truth_table because
//           "table" is a reserved word.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module minterm_sweep_checker
    import minterm_sweep_pkg::*;
#(
    parameter int          DUT_LAT  = 1,
    parameter logic [15:0] EXPECTED = 16'h686C
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  resp,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic                  d,
    output logic [M_W-1:0]        m,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_MINTERMS-1:0] truth_table
`ifdef MINTERM_SWEEP_FAIL_LOG_EN
    ,
    output logic [M_W-1:0]        first_fail,
    output logic [4:0]            fail_cnt
`endif
);

    logic [1:0]            state_q, state_d;
    logic [N_MINTERMS-1:0] table_q, table_d;
    logic                  pass_q, pass_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [N_MINTERMS-1:0] w_table_cap;
    logic                  w_go;
    logic                  w_capture;
    logic                  w_last;
    logic [M_W-1:0]        w_m;

    assign w_go = start && (state_q != S_RUN);

    sweep_slot_counter #(
        .DUT_LAT (DUT_LAT)
    ) u_slot_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_go),
        .run     (state_q == S_RUN),
        .m       (w_m),
        .capture (w_capture),
        .last    (w_last)
    );

    always_comb begin
        state_d          = state_q;
        table_d          = table_q;
        pass_d           = pass_q;
        w_table_cap      = table_q;
        w_table_cap[w_m] = resp;
        if (w_go) begin
            state_d = S_RUN;
            table_d = '0;
            pass_d  = 1'b0;
        end else if (w_capture) begin
            table_d = w_table_cap;
            if (w_last) begin
                state_d = S_DONE;
                // 4-state compare so a captured X/Z can never report a pass.
                pass_d  = (w_table_cap === EXPECTED);
            end
        end
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            table_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            table_q <= table_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {a, b, c, d} = w_m;
    assign m            = w_m;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign truth_table  = table_q;

`ifdef MINTERM_SWEEP_FAIL_LOG_EN
    logic [M_W-1:0] first_fail_q, first_fail_d;
    logic [4:0]     fail_cnt_q, fail_cnt_d;
    logic           w_miss;

    assign w_miss = (resp !== EXPECTED[w_m]);

    always_comb begin
        first_fail_d = first_fail_q;
        fail_cnt_d   = fail_cnt_q;
        if (w_go) begin
            first_fail_d = '0;
            fail_cnt_d   = '0;
        end else if (w_capture && w_miss) begin
            fail_cnt_d = fail_cnt_q + 1'b1;
            // Captures run in ascending order, so the first miss is the lowest.
            if (fail_cnt_q == 5'd0) begin
                first_fail_d = w_m;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_fail_q <= '0;
            fail_cnt_q   <= '0;
        end else begin
            first_fail_q <= first_fail_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign first_fail = first_fail_q;
    assign fail_cnt   = fail_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_minterm_sweep_checker.sv
//------------------------------------------------------------------------------
// Module  : tb_minterm_sweep_checker
// Brief   : Directed scoreboard bench for minterm_sweep_checker (latency 1 and 2).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_minterm_sweep_checker;

    localparam logic [15:0] REF_TT = 16'h686C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start1, start2;
    logic        resp1, resp2, s2a;
    logic        a1, b1, c1, d1, a2, b2, c2, d2;
    logic [3:0]  m1, m2;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0] tt1, tt2;
    logic [3:0]  ff1, ff2;
    logic [4:0]  fc1, fc2;

    int n_cmp  = 0;
    int n_fail = 0;
    int mode   = 0;   // 0 reference, 1 force 1 at minterm 7, 2 stuck at 0

    typedef struct {
        logic [15:0] tt;
        logic        pass;
        logic [3:0]  ff;
        logic [4:0]  fc;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    minterm_sweep_checker u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .resp(resp1),
        .a(a1), .b(b1), .c(c1), .d(d1), .m(m1),
        .busy(busy1), .done(done1), .pass(pass1), .truth_table(tt1)
`ifdef MINTERM_SWEEP_FAIL_LOG_EN
        , .first_fail(ff1), .fail_cnt(fc1)
`endif
    );

    minterm_sweep_checker #(.DUT_LAT(2), .EXPECTED(16'h686C)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .resp(resp2),
        .a(a2), .b(b2), .c(c2), .d(d2), .m(m2),
        .busy(busy2), .done(done2), .pass(pass2), .truth_table(tt2)
`ifdef MINTERM_SWEEP_FAIL_LOG_EN
        , .first_fail(ff2), .fail_cnt(fc2)
`endif
    );

`ifndef MINTERM_SWEEP_FAIL_LOG_EN
    assign ff1 = 4'd0;
    assign fc1 = 5'd0;
    assign ff2 = 4'd0;
    assign fc2 = 5'd0;
`endif

    function automatic logic stage_in(input logic [3:0] mm);
        logic [15:0] t;
        t = REF_TT;
        case (mode)
            1:       return (mm == 4'd7) ? 1'b1 : t[mm];
            2:       return 1'b0;
            default: return t[mm];
        endcase
    endfunction

    // Behavioural models of the checked stage: 1 and 2 register stages.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            resp1 <= 1'b0;
            s2a   <= 1'b0;
            resp2 <= 1'b0;
        end else begin
            resp1 <= stage_in({a1, b1, c1, d1});
            s2a   <= stage_in({a2, b2, c2, d2});
            resp2 <= s2a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 2) ? done2 : done1;
    endfunction

    function automatic logic [3:0] get_m(input int sel);
        return (sel == 2) ? m2 : m1;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 2) start2 = v;
        else          start1 = v;
    endtask

    task automatic run_sweep(input int sel, input int lat, input logic [15:0] ett,
                             input logic ep, input logic [3:0] eff, input logic [4:0] efc,
                             input int repulse_m);
        exp_t e;
        int   cnt;
        bit   pulsed;
        sb.push_back('{tt: ett, pass: ep, ff: eff, fc: efc, cyc: 16 * (lat + 1)});
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        chk("busy_after_start", (sel == 2) ? busy2 : busy1, 1);
        chk("done_drop",        get_done(sel), 0);
        chk("m_first",          get_m(sel), 0);
        cnt    = 0;
        pulsed = 0;
        while (!get_done(sel) && cnt < 400) begin
            if (repulse_m >= 0 && !pulsed && get_m(sel) == 4'(repulse_m)) begin
                set_start(sel, 1'b1);
                pulsed = 1;
            end
            @(negedge clk);
            set_start(sel, 1'b0);
            cnt++;
            if (sel == 1 && cnt == 3) chk("abcd_eq_m", {a1, b1, c1, d1}, m1);
        end
        e = sb.pop_front();
        chk("sweep_cycles", cnt, e.cyc);
        if (sel == 2) begin
            chk("table", tt2, e.tt);
            chk("pass",  pass2, e.pass);
            chk("busy_done", busy2, 0);
            chk("m_last", m2, 15);
`ifdef MINTERM_SWEEP_FAIL_LOG_EN
            chk("first_fail", ff2, e.ff);
            chk("fail_cnt",   fc2, e.fc);
`endif
        end else begin
            chk("table", tt1, e.tt);
            chk("pass",  pass1, e.pass);
            chk("busy_done", busy1, 0);
            chk("m_last", m1, 15);
`ifdef MINTERM_SWEEP_FAIL_LOG_EN
            chk("first_fail", ff1, e.ff);
            chk("fail_cnt",   fc1, e.fc);
`endif
        end
        @(negedge clk);
        chk("done_hold",  get_done(sel), 1);
        chk("table_hold", (sel == 2) ? tt2 : tt1, e.tt);
    endtask

    initial begin
        int guard;
        reset  = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_m",     m1, 0);
        chk("rst_busy",  busy1, 0);
        chk("rst_done",  done1, 0);
        chk("rst_pass",  pass1, 0);
        chk("rst_table", tt1, 16'h0000);
        chk("rst_table2", tt2, 16'h0000);
        reset = 1'b0;

        // Reference sweep at latency 1.
        mode = 0;
        run_sweep(1, 1, 16'h686C, 1'b1, 4'd0, 5'd0, -1);

        // Stage wrongly answers 1 at minterm 7.
        mode = 1;
        run_sweep(1, 1, 16'h68EC, 1'b0, 4'd7, 5'd1, -1);

        // Latency 2 with an ignored start re-pulse at minterm 5.
        mode = 0;
        run_sweep(2, 2, 16'h686C, 1'b1, 4'd0, 5'd0, 5);

        // Asynchronous reset during minterm 9 aborts the sweep.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        guard = 0;
        while (m1 != 4'd9 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_m9", m1, 9);
        #2 reset = 1'b1;
        #1;
        chk("arst_m",     m1, 0);
        chk("arst_abcd",  {a1, b1, c1, d1}, 0);
        chk("arst_busy",  busy1, 0);
        chk("arst_done",  done1, 0);
        chk("arst_pass",  pass1, 0);
        chk("arst_table", tt1, 16'h0000);
`ifdef MINTERM_SWEEP_FAIL_LOG_EN
        chk("arst_fail_cnt", fc1, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        run_sweep(1, 1, 16'h686C, 1'b1, 4'd0, 5'd0, -1);

        // Restart from DONE with the stage stuck at 0.
        mode = 2;
        run_sweep(1, 1, 16'h0000, 1'b0, 4'd2, 5'd7, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/minterm_sweep_checker.md
Name: minterm_sweep_checker

Overview:
- Self-checking sweep stage that sits directly around the registered 4-input simplification stage.
- Upstream role: drives minterms m = 0..15 onto a, b, c, d.
- Downstream role: after the stage's register latency, captures the registered output bit for each minterm into a 16-bit truth table.
- On completion, compares the table against an expected mask and reports pass/fail. This replaces the hand-written stimulus list and visual log inspection.

Parameters:
- DUT_LAT, 1: clock edges between driving a minterm and that minterm's response being valid on resp; legal range 1..7.
- EXPECTED, 16'h686C: golden truth table; bit k is the required response for minterm k.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- resp  in  1  registered output of the checked stage.
- a  out  1  minterm bit 3 (MSB).
- b  out  1  minterm bit 2.
- c  out  1  minterm bit 1.
- d  out  1  minterm bit 0 (LSB).
- m  out  4  current minterm index; {a,b,c,d} == m at all times.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  valid while done=1: table == EXPECTED.
- table  out  16  captured truth table; bit k is the response for minterm k.

Behaviour:
- Reset: asynchronous and active-high. While reset is high, and on its release:
  - state=IDLE, m=0, a=b=c=d=0, wait_cnt=0;
  - busy=0, done=0, pass=0, table=16'h0000.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN; m=0, wait_cnt=0, table cleared to 0.
  - Otherwise hold.
- RUN, minterm m is driven throughout its slot:
  - wait_cnt increments each cycle.
  - When wait_cnt == DUT_LAT: table[m] <= resp and wait_cnt <= 0.
  - If m == 15 -> DONE in the same edge; pass <= ({resp, table[14:0]} == EXPECTED), i.e. the compare includes the bit being captured on that edge.
  - Else m <= m+1.
- Slot timing: each minterm slot lasts DUT_LAT+1 cycles. Full sweep = 16*(DUT_LAT+1) cycles from the start edge to done rising; 32 cycles at the default.
- done/busy are registered: busy=1 exactly in RUN; done=1 exactly in DONE.
- start while in RUN is ignored; there is no restart mid-sweep.
- DONE:
  - m holds 15; table and pass hold.
  - start=1 -> RUN with the same initialisation as from IDLE, so done drops the cycle after start.
- Wrap-around: m never wraps to 0 inside a sweep; the m==15 capture is terminal.
- resp = X/Z is captured as-is. Because table is then not 4-state equal to EXPECTED, pass=0.
- Reset asserted mid-RUN aborts immediately to the reset values; no partial result is retained.

Optional Feature:
- Macro: MINTERM_SWEEP_FAIL_LOG_EN.
- Defined: adds two output ports.
  - first_fail, 4 bits: lowest k where table[k] != EXPECTED[k].
  - fail_cnt, 5 bits: number of mismatching minterms, 0..16.
  - Both are updated incrementally at each capture, reset to 0, and cleared on start.
  - first_fail holds 0 when fail_cnt == 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package minterm_sweep_pkg:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - N_MINTERMS=16, M_W=4, LAT_W=3.
- One sub-module: sweep_slot_counter.
  - Holds wait_cnt and m.
  - Outputs a one-cycle capture strobe and a last-minterm flag to the FSM.
  - Contains no compare logic.

Test Plan:
- Default parameters, bench models the stage as a DFF on the reference function, start pulsed at t0 -> m steps 0..15; done rises 32 cycles after start; table=16'h686C; pass=1.
- Same setup with the model forcing resp=1 at minterm 7 -> table=16'h68EC, pass=0. With MINTERM_SWEEP_FAIL_LOG_EN: first_fail=7, fail_cnt=1.
- DUT_LAT=2 with a 2-stage model, plus start re-pulsed at minterm 5 -> the re-pulse is ignored; done after 48 cycles; table=16'h686C; pass=1.
- reset asserted asynchronously (between edges) during minterm 9 -> all outputs reach reset values immediately. A new start then completes with pass=1.
- In DONE with pass=1, assert start again with resp stuck at 0 -> done drops the next cycle; after 32 cycles table=16'h0000, pass=0. With MINTERM_SWEEP_FAIL_LOG_EN: fail_cnt=7, first_fail=2.
